// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer_pkg
//  Description : Shared definitions for the shift sequencer: opcode values,
//                shifter direction codes and FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_sequencer_pkg;

    // Opcodes; 3'b101..3'b111 are pass-through.
    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    // Shifter direction control.
    localparam logic CTRL_LSL = 1'b0;
    localparam logic CTRL_LSR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Rotates and arithmetic shift need a second shifter pass.
    function automatic logic is_two_pass(input logic [2:0] op);
        return (op == OP_ROL) || (op == OP_ROR) || (op == OP_ASR);
    endfunction

endpackage : shift_sequencer_pkg
`default_nettype wire

// File: rtl/shift_sequencer_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer_shifter
//  Description : n-bit LSL/LSR barrel shifter shared by both requesters.
//  Ports       : a    - data in (2**MAX_S_BITS bits)
//                b    - shift amount (MAX_S_BITS bits)
//                ctrl - 0 = logical shift left, 1 = logical shift right
//                y    - shifted data out (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module shift_sequencer_shifter #(
    parameter int MAX_S_BITS = 3
) (
    input  logic [(2**MAX_S_BITS)-1:0] a,
    input  logic [MAX_S_BITS-1:0]      b,
    input  logic                       ctrl,
    output logic [(2**MAX_S_BITS)-1:0] y
);

    always_comb begin
        if (ctrl) begin
            y = a >> b;
        end else begin
            y = a << b;
        end
    end

endmodule : shift_sequencer_shifter
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Two-port round-robin front end sharing one LSL/LSR shifter.
//                Sequences one or two shifter passes per op to provide
//                LSL, LSR, ROL, ROR, ASR and pass-through.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                req0/op0/a0/b0      - port 0 request, opcode, data, amount
//                req1/op1/a1/b1      - port 1 request, opcode, data, amount
//                ack0, ack1          - one-cycle result-valid pulses
//                result              - registered result
//                busy                - high whenever the FSM is not idle
//  Revision    : 1.0  initial release
// ============================================================================
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int MAX_S_BITS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req0,
    input  logic [2:0]                 op0,
    input  logic [(2**MAX_S_BITS)-1:0] a0,
    input  logic [MAX_S_BITS-1:0]      b0,
    input  logic                       req1,
    input  logic [2:0]                 op1,
    input  logic [(2**MAX_S_BITS)-1:0] a1,
    input  logic [MAX_S_BITS-1:0]      b1,
    output logic                       ack0,
    output logic                       ack1,
    output logic [(2**MAX_S_BITS)-1:0] result,
    output logic                       busy
);

    localparam int W = 2**MAX_S_BITS;
    localparam logic [MAX_S_BITS-1:0] c_one = {{(MAX_S_BITS-1){1'b0}}, 1'b1};

    state_t                r_state;
    logic [2:0]            r_op;
    logic [W-1:0]          r_a;
    logic [MAX_S_BITS-1:0] r_b;
    logic [W-1:0]          r_tmp;
    logic                  r_gnt;
    logic                  r_last_grant;

    logic [W-1:0]          w_sh_a;
    logic [MAX_S_BITS-1:0] w_sh_b;
    logic                  w_sh_ctrl;
    logic [W-1:0]          w_sh_y;
    logic [MAX_S_BITS-1:0] w_nb;
    logic [W-1:0]          w_asr_fill;
    logic [W-1:0]          w_pass2_result;
    logic                  w_gnt;

    // Complementary amount for the second half of a rotate: (-b) mod W.
    assign w_nb = ~r_b + c_one;

    // Contended: alternate away from the last winner. Otherwise whoever asks.
    assign w_gnt = (req0 && req1) ? ~r_last_grant : req1;

    // Shifter operand selection per pass.
    always_comb begin
        w_sh_a    = r_a;
        w_sh_b    = r_b;
        w_sh_ctrl = CTRL_LSL;
        case (r_state)
            ST_PASS1: begin
                case (r_op)
                    OP_LSL, OP_ROL:         w_sh_ctrl = CTRL_LSL;
                    OP_LSR, OP_ROR, OP_ASR: w_sh_ctrl = CTRL_LSR;
                    default:                w_sh_b    = '0;
                endcase
            end
            ST_PASS2: begin
                case (r_op)
                    OP_ROL: begin
                        w_sh_b    = w_nb;
                        w_sh_ctrl = CTRL_LSR;
                    end
                    OP_ROR: begin
                        w_sh_b    = w_nb;
                        w_sh_ctrl = CTRL_LSL;
                    end
                    OP_ASR: begin
                        // All-ones shifted right marks the bits that survived;
                        // its complement is where the sign must be filled.
                        w_sh_a    = '1;
                        w_sh_ctrl = CTRL_LSR;
                    end
                    default: begin
                        w_sh_b    = '0;
                    end
                endcase
            end
            default: begin
                w_sh_b = '0;
            end
        endcase
    end

    // With b = 0 a rotate's second pass also returns r_a, so the OR is r_a.
    assign w_asr_fill     = r_a[W-1] ? ~w_sh_y : '0;
    assign w_pass2_result = (r_op == OP_ASR) ? (r_tmp | w_asr_fill)
                                             : (r_tmp | w_sh_y);

    shift_sequencer_shifter #(
        .MAX_S_BITS (MAX_S_BITS)
    ) u_n_bit_shifter (
        .a    (w_sh_a),
        .b    (w_sh_b),
        .ctrl (w_sh_ctrl),
        .y    (w_sh_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_tmp        <= '0;
            r_gnt        <= 1'b0;
            r_last_grant <= 1'b1;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            result       <= '0;
            busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        r_gnt        <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_op         <= w_gnt ? op1 : op0;
                        r_a          <= w_gnt ? a1  : a0;
                        r_b          <= w_gnt ? b1  : b0;
                        busy         <= 1'b1;
                        r_state      <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    r_tmp <= w_sh_y;
                    if (is_two_pass(r_op)) begin
                        r_state <= ST_PASS2;
                    end else begin
                        result  <= w_sh_y;
                        ack0    <= ~r_gnt;
                        ack1    <= r_gnt;
                        r_state <= ST_DONE;
                    end
                end
                ST_PASS2: begin
                    result  <= w_pass2_result;
                    ack0    <= ~r_gnt;
                    ack1    <= r_gnt;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : shift_sequencer
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_sequencer
//  Description : Self-checking bench for shift_sequencer (W = 8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [2:0] op0, op1;
    logic [7:0] a0, a1;
    logic [2:0] b0, b1;
    logic       ack0, ack1, busy;
    logic [7:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_sequencer #(
        .MAX_S_BITS (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .op0    (op0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .op1    (op1),
        .a1     (a1),
        .b1     (b1),
        .ack0   (ack0),
        .ack1   (ack1),
        .result (result),
        .busy   (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: rotates/ASR from integer arithmetic on an 8-bit value.
    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a,
                                         input logic [2:0] b);
        int ai;
        int s;
        int sa;
        ai = int'(a);
        s  = int'(b);
        case (op)
            3'd0:    return 8'((ai << s) & 255);
            3'd1:    return 8'(ai >> s);
            3'd2:    return 8'(((ai << s) | (ai >> (8 - s))) & 255);
            3'd3:    return 8'(((ai >> s) | (ai << (8 - s))) & 255);
            3'd4: begin
                sa = (ai >= 128) ? ai - 256 : ai;
                return 8'((sa >>> s) & 255);
            end
            default: return a;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op);
        return (op == 3'd2 || op == 3'd3 || op == 3'd4) ? 3 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int port, input logic [2:0] op, input logic [7:0] a,
                         input logic [2:0] b);
        if (port == 0) begin
            op0 = op; a0 = a; b0 = b;
        end else begin
            op1 = op; a1 = a; b1 = b;
        end
    endtask

    task automatic set_req(input int port, input logic v);
        if (port == 0) req0 = v;
        else           req1 = v;
    endtask

    // Issue one op from idle; checks latency, result, busy and ack exclusivity.
    task automatic do_op(input string tag, input int port, input logic [2:0] op,
                         input logic [7:0] a, input logic [2:0] b);
        int         lat;
        bit         got;
        logic [7:0] exp;
        exp = model(op, a, b);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        drive(port, op, a, b);
        set_req(port, 1'b1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 1) drive(port, 3'($urandom), 8'($urandom), 3'($urandom));
            got = (port == 0) ? ack0 : ack1;
            if (!got) check({tag, "_busy"}, 32'(busy), 32'd1);
        end
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_latency(op)));
        check({tag, "_result"}, 32'(result), 32'(exp));
        check({tag, "_other_ack"}, 32'((port == 0) ? ack1 : ack0), 32'd0);
        set_req(port, 1'b0);
        @(negedge clk);
        check({tag, "_ack_clear"}, 32'(ack0 | ack1), 32'd0);
    endtask

    // Wait (bounded) for any ack; returns which port acked, or -1.
    task automatic wait_ack(output int port);
        int n;
        n = 0;
        while (!(ack0 || ack1) && n < 10) begin
            @(negedge clk);
            n++;
        end
        port = ack0 ? 0 : (ack1 ? 1 : -1);
    endtask

    initial begin
        int         p;
        int         exp_port;
        logic [2:0] rop;

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_acks", 32'({ack0, ack1}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed single ops
        do_op("lsl",      0, 3'd0, 8'h81, 3'd1);
        do_op("rol",      1, 3'd2, 8'h81, 3'd1);
        do_op("ror",      1, 3'd3, 8'h01, 3'd3);
        do_op("rol_b0",   1, 3'd2, 8'h5A, 3'd0);
        do_op("ror_b0",   0, 3'd3, 8'hA5, 3'd0);
        do_op("asr_neg",  0, 3'd4, 8'h90, 3'd2);
        do_op("asr_pos",  1, 3'd4, 8'h70, 3'd2);
        do_op("lsr",      0, 3'd1, 8'h90, 3'd2);
        do_op("pass",     1, 3'd7, 8'h3C, 3'd5);
        do_op("asr_max",  0, 3'd4, 8'h80, 3'd7);

        // Contention from reset: grants alternate 0,1,0,1
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(0, 3'd0, 8'h0F, 3'd2);
        drive(1, 3'd3, 8'h0F, 3'd4);
        req0 = 1'b1; req1 = 1'b1;
        exp_port = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(p);
            check("arb_port", 32'(p), 32'(exp_port));
            check("arb_one_ack", 32'(ack0 & ack1), 32'd0);
            if (p == 0) check("arb_result0", 32'(result), 32'(model(3'd0, 8'h0F, 3'd2)));
            else        check("arb_result1", 32'(result), 32'(model(3'd3, 8'h0F, 3'd4)));
            if (p >= 0) set_req(p, 1'b0);
            @(negedge clk);
            if (p >= 0) set_req(p, 1'b1);
            exp_port = 1 - exp_port;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during PASS2 of a ROR
        drive(1, 3'd3, 8'h01, 3'd3);
        req1 = 1'b1;
        @(negedge clk);
        check("rst_mid_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        check("rst_mid_busy2", 32'(busy), 32'd1);
        check("rst_mid_noack", 32'(ack1), 32'd0);
        reset = 1'b1;
        drive(0, 3'd4, 8'h90, 3'd2);
        drive(1, 3'd1, 8'h90, 3'd2);
        req0 = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_acks", 32'({ack0, ack1}), 32'd0);
        reset = 1'b0;
        wait_ack(p);
        check("post_rst_first", 32'(p), 32'd0);
        check("post_rst_res0", 32'(result), 32'(model(3'd4, 8'h90, 3'd2)));
        req0 = 1'b0;
        @(negedge clk);
        wait_ack(p);
        check("post_rst_second", 32'(p), 32'd1);
        check("post_rst_res1", 32'(result), 32'(model(3'd1, 8'h90, 3'd2)));
        req1 = 1'b0;
        @(negedge clk);

        // req0 held one extra cycle after ack0 -> second request
        drive(0, 3'd1, 8'h90, 3'd2);
        req0 = 1'b1;
        wait_ack(p);
        check("hold_first", 32'(p), 32'd0);
        check("hold_res1", 32'(result), 32'(model(3'd1, 8'h90, 3'd2)));
        drive(0, 3'd0, 8'h81, 3'd3);
        @(negedge clk);
        check("hold_idle_ack", 32'(ack0), 32'd0);
        @(negedge clk);
        req0 = 1'b0;
        drive(0, 3'd7, 8'hFF, 3'd0);
        check("hold_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("hold_second_ack", 32'(ack0), 32'd1);
        check("hold_res2", 32'(result), 32'(model(3'd0, 8'h81, 3'd3)));
        @(negedge clk);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            do_op("rand", int'($urandom_range(0, 1)), rop, 8'($urandom), 3'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shift_sequencer
`default_nettype wire
